// File: rtl/ring_buffer_pkg.sv
// rtl/ring_buffer_pkg.sv - shared types and per-edge action decode for ring_buffer
package ring_buffer_pkg;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_PUSH,
        ACT_POP,
        ACT_SWAP
    } rb_action_e;

    // ACT_SWAP covers both push+pop and overwrite-while-full: write, advance both pointers, count unchanged.
    function automatic rb_action_e rb_decide(input logic enq, input logic deq,
                                             input logic is_full, input logic is_empty,
                                             input logic ovw);
        rb_action_e act;
        act = ACT_NONE;
        if (enq && deq)
            act = is_empty ? ACT_PUSH : ACT_SWAP;
        else if (enq)
            act = !is_full ? ACT_PUSH : (ovw ? ACT_SWAP : ACT_NONE);
        else if (deq)
            act = !is_empty ? ACT_POP : ACT_NONE;
        return act;
    endfunction

endpackage

// File: rtl/ring_buffer.sv
// rtl/ring_buffer.sv - parameterised first-word-fall-through circular FIFO with optional overwrite
module ring_buffer
    import ring_buffer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int LENGTH       = 8,
    parameter int OVERWRITABLE = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enqueue_i,
    input  logic             dequeue_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(LENGTH);
    localparam int CW = $clog2(LENGTH + 1);

    logic [WIDTH-1:0] mem [LENGTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    rb_action_e       act;

    // LENGTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(LENGTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full   = (count == CW'(LENGTH));
    assign empty  = (count == '0);
    assign data_o = empty ? '0 : mem[rd_ptr];
    assign act    = rb_decide(enqueue_i, dequeue_i, full, empty, OVERWRITABLE != 0);

    // rstn is active-high despite its name.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (act)
                ACT_PUSH: begin
                    wr_ptr <= next_ptr(wr_ptr);
                    count  <= count + CW'(1);
                end
                ACT_POP: begin
                    rd_ptr <= next_ptr(rd_ptr);
                    count  <= count - CW'(1);
                end
                ACT_SWAP: begin
                    wr_ptr <= next_ptr(wr_ptr);
                    rd_ptr <= next_ptr(rd_ptr);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn && (act == ACT_PUSH || act == ACT_SWAP))
            mem[wr_ptr] <= data_i;
    end

endmodule

// File: tb/tb_ring_buffer.sv
// tb/tb_ring_buffer.sv - self-checking bench: queue model for a drop-mode and an overwrite-mode instance
module tb_ring_buffer;

    localparam int L = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       e  [2];
    logic       d  [2];
    logic [7:0] di [2];
    logic [7:0] dout [2];
    logic       fl [2];
    logic       em [2];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ring_buffer #(.WIDTH(8), .LENGTH(L), .OVERWRITABLE(0)) dut0 (
        .clk(clk), .rstn(rst), .enqueue_i(e[0]), .dequeue_i(d[0]), .data_i(di[0]),
        .data_o(dout[0]), .full(fl[0]), .empty(em[0])
    );

    ring_buffer #(.WIDTH(8), .LENGTH(L), .OVERWRITABLE(1)) dut1 (
        .clk(clk), .rstn(rst), .enqueue_i(e[1]), .dequeue_i(d[1]), .data_i(di[1]),
        .data_o(dout[1]), .full(fl[1]), .empty(em[1])
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: what a FIFO of capacity L must do, independent of pointer mechanics.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (e[0] && d[0]) begin
                if (q0.size() == 0) q0.push_back(di[0]);
                else begin void'(q0.pop_front()); q0.push_back(di[0]); end
            end else if (e[0]) begin
                if (q0.size() < L) q0.push_back(di[0]);
            end else if (d[0] && q0.size() > 0) begin
                void'(q0.pop_front());
            end
            if (e[1] && d[1]) begin
                if (q1.size() == 0) q1.push_back(di[1]);
                else begin void'(q1.pop_front()); q1.push_back(di[1]); end
            end else if (e[1]) begin
                if (q1.size() == L) void'(q1.pop_front());
                q1.push_back(di[1]);
            end else if (d[1] && q1.size() > 0) begin
                void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        check("m0_data", dout[0], (q0.size() > 0) ? q0[0] : 8'h00);
        check("m0_full", {7'b0, fl[0]}, {7'b0, q0.size() == L});
        check("m0_empty", {7'b0, em[0]}, {7'b0, q0.size() == 0});
        check("m1_data", dout[1], (q1.size() > 0) ? q1[0] : 8'h00);
        check("m1_full", {7'b0, fl[1]}, {7'b0, q1.size() == L});
        check("m1_empty", {7'b0, em[1]}, {7'b0, q1.size() == 0});
    end

    task automatic step(input int k, input logic en, input logic de, input logic [7:0] v);
        e[k] = en; d[k] = de; di[k] = v;
        @(posedge clk); #1;
        e[k] = 1'b0; d[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin e[k] = 0; d[k] = 0; di[k] = 0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", {7'b0, em[0]}, 8'h01);
        check("rst_full", {7'b0, fl[0]}, 8'h00);
        check("rst_data", dout[0], 8'h00);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_empty", {7'b0, em[0]}, 8'h01);

        // Fill: a..e stored, f..p dropped
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 8'h61 + 8'(i));
            if (i == 3) check("fill_not_full_4", {7'b0, fl[0]}, 8'h00);
            if (i == 4) check("fill_full_5", {7'b0, fl[0]}, 8'h01);
        end
        check("fill_head", dout[0], "a");
        // E=D while full in drop mode: pop a, push z
        step(0, 1, 1, "z");
        check("full_swap_head", dout[0], "b");
        check("full_swap_full", {7'b0, fl[0]}, 8'h01);

        // Drain: b,c,d,e,z then ignored pops
        for (int i = 0; i < 16; i++) begin
            if (i == 0) check("drain0", dout[0], "b");
            if (i == 3) check("drain3", dout[0], "e");
            if (i == 4) check("drain4", dout[0], "z");
            step(0, 0, 1, 8'h00);
        end
        check("drain_empty", {7'b0, em[0]}, 8'h01);
        check("drain_data0", dout[0], 8'h00);

        // Simultaneous from empty: ends holding 'p'
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1, 8'h61 + 8'(i));
            if (i == 5) check("simul_head", dout[0], "f");
        end
        check("simul_last", dout[0], "p");
        check("simul_not_full", {7'b0, fl[0]}, 8'h00);
        step(0, 0, 1, 8'h00);
        check("simul_empty", {7'b0, em[0]}, 8'h01);

        // Wrap-around: push 3, pop 3, push 5, pop 5
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h30 + 8'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h10 + 8'(i));
        check("wrap_full", {7'b0, fl[0]}, 8'h01);
        for (int i = 0; i < 5; i++) begin
            check("wrap_order", dout[0], 8'h10 + 8'(i));
            step(0, 0, 1, 8'h00);
        end
        check("wrap_empty", {7'b0, em[0]}, 8'h01);

        // Overwrite mode: a..g leaves c..g
        for (int i = 0; i < 7; i++) step(1, 1, 0, 8'h61 + 8'(i));
        check("ovw_full", {7'b0, fl[1]}, 8'h01);
        check("ovw_head", dout[1], "c");
        step(1, 1, 1, "h");
        check("ovw_swap_full", {7'b0, fl[1]}, 8'h01);
        check("ovw_swap_head", dout[1], "d");
        for (int i = 0; i < 5; i++) begin
            check("ovw_drain", dout[1], 8'h64 + 8'(i));
            step(1, 0, 1, 8'h00);
        end
        check("ovw_empty", {7'b0, em[1]}, 8'h01);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h40 + 8'(i));
        #2 rst = 1'b1;
        #1;
        check("async_rst_empty", {7'b0, em[0]}, 8'h01);
        check("async_rst_data", dout[0], 8'h00);
        rst = 1'b0;
        step(0, 1, 0, 8'h77);
        check("post_rst_head", dout[0], 8'h77);
        check("post_rst_nonempty", {7'b0, em[0]}, 8'h00);
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
